// File: rtl/voice_mixer.sv
// voice_mixer: time-multiplexed voice summing stage.
// Accumulates one signed 16-bit sample per voice slot over a frame of
// NUM_VOICES slots, scales the completed frame by an arithmetic right shift
// and presents it on a valid/ready output register. Sequencing faults and
// output overruns are reported on sticky flags.
// Optional feature: define VOICE_MIXER_SATURATE_EN to clamp the scaled frame
// to the signed 16-bit range; otherwise the result wraps (two's complement).
module voice_mixer #(
  parameter int NUM_VOICES = 16,
  parameter int ACC_WIDTH  = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_voice,
  input  logic [15:0] in_sample,
  input  logic [3:0]  gain_shift,
  input  logic        clear_flags,
  output logic [15:0] out_sample,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        seq_err,
  output logic        overrun
);

  // Nine bits so that NUM_VOICES = 256 is representable.
  localparam logic [8:0] NV_LIMIT   = 9'(NUM_VOICES);
  localparam logic [7:0] LAST_VOICE = 8'(NUM_VOICES - 1);

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [7:0]                  r_expect;
  logic                        r_drop;
  logic [15:0]                 r_out_sample;
  logic                        r_out_valid;
  logic                        r_seq_err;
  logic                        r_overrun;

  logic                        w_accept;
  logic                        w_start;
  logic                        w_in_order;
  logic                        w_bad;
  logic                        w_done;
  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic [15:0]                 w_out;

  // Slot classification: out-of-range voices are invisible to the mixer.
  assign w_accept   = in_valid && ({1'b0, in_voice} < NV_LIMIT);
  assign w_start    = w_accept && (in_voice == 8'd0);
  assign w_in_order = w_accept && !w_start && !r_drop && (in_voice == r_expect);
  assign w_bad      = w_accept && !w_start && !w_in_order;
  assign w_done     = w_in_order && (in_voice == LAST_VOICE);

  assign w_ext = {{(ACC_WIDTH-16){in_sample[15]}}, in_sample};
  assign w_sum = r_acc + w_ext;

`ifdef VOICE_MIXER_SATURATE_EN
  logic signed [ACC_WIDTH-1:0] w_full;
  logic [ACC_WIDTH-16:0]       w_hi;

  assign w_full = w_sum >>> gain_shift;
  assign w_hi   = w_full[ACC_WIDTH-1:15];

  // Clamp the scaled frame when the bits above bit 15 are not a pure sign extension.
  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    w_out = w_full[15:0];
    if (!((&w_hi) || !(|w_hi))) begin
      w_out = w_full[ACC_WIDTH-1] ? 16'h8000 : 16'h7fff;
    end
  end
`else
  // Wrapping build: keep only the low 16 bits of the scaled frame.
  assign w_out = 16'(w_sum >>> gain_shift);
`endif

  // Frame accumulator and slot sequencing state.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc    <= '0;
      r_expect <= 8'd0;
      r_drop   <= 1'b1;
    end else if (w_start) begin
      r_acc    <= w_ext;
      r_expect <= 8'd1;
      r_drop   <= 1'b0;
    end else if (w_done) begin
      r_acc    <= w_sum;
      r_expect <= 8'd0;
      r_drop   <= 1'b1;
    end else if (w_in_order) begin
      r_acc    <= w_sum;
      r_expect <= r_expect + 8'd1;
    end else if (w_bad) begin
      r_drop   <= 1'b1;
    end
  end

  // Output register with valid/ready handshake; a load always wins over a handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_sample <= 16'd0;
      r_out_valid  <= 1'b0;
    end else if (w_done) begin
      r_out_sample <= w_out;
      r_out_valid  <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Sticky fault flags; a setting event takes priority over clear_flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seq_err <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_bad) begin
        r_seq_err <= 1'b1;
      end else if (clear_flags) begin
        r_seq_err <= 1'b0;
      end
      if (w_done && r_out_valid && !out_ready) begin
        r_overrun <= 1'b1;
      end else if (clear_flags) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign out_sample = r_out_sample;
  assign out_valid  = r_out_valid;
  assign seq_err    = r_seq_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_voice_mixer.sv
// Testbench for voice_mixer (NUM_VOICES = 4): directed scenarios followed by
// randomized slot traffic, all compared against a frame-level reference model.
module tb_voice_mixer;

  localparam int NV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_voice;
  logic [15:0] in_sample;
  logic [3:0]  gain_shift;
  logic        clear_flags;
  logic [15:0] out_sample;
  logic        out_valid;
  logic        out_ready;
  logic        seq_err;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  // Reference model: the frame is kept as a list of collected samples.
  int          frame[$];
  bit          collecting;
  logic        m_valid;
  logic [15:0] m_sample;
  logic        m_seq;
  logic        m_ovr;

  voice_mixer #(.NUM_VOICES(NV), .ACC_WIDTH(24)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_voice    (in_voice),
    .in_sample   (in_sample),
    .gain_shift  (gain_shift),
    .clear_flags (clear_flags),
    .out_sample  (out_sample),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .seq_err     (seq_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"},  {31'd0, out_valid}, {31'd0, m_valid});
    check({tag, ".out_sample"}, {16'd0, out_sample}, {16'd0, m_sample});
    check({tag, ".seq_err"},    {31'd0, seq_err}, {31'd0, m_seq});
    check({tag, ".overrun"},    {31'd0, overrun}, {31'd0, m_ovr});
  endtask

  task automatic model_reset();
    frame.delete();
    collecting = 1'b0;
    m_valid    = 1'b0;
    m_sample   = 16'd0;
    m_seq      = 1'b0;
    m_ovr      = 1'b0;
  endtask

  // Scale a frame total and reduce it to 16 bits.
  function automatic logic [15:0] scale(input int sum, input int g);
    int full;
    full = sum >>> g;
`ifdef VOICE_MIXER_SATURATE_EN
    if (full > 32767) full = 32767;
    if (full < -32768) full = -32768;
`endif
    return full[15:0];
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit          load;
    bit          seq_set;
    bit          ovr_set;
    logic [15:0] ld;
    int          sum;
    load = 0; seq_set = 0; ovr_set = 0; ld = 16'd0;
    if (in_valid && int'(in_voice) < NV) begin
      if (in_voice == 8'd0) begin
        frame.delete();
        frame.push_back(int'($signed(in_sample)));
        collecting = 1'b1;
      end else if (collecting && int'(in_voice) == frame.size()) begin
        frame.push_back(int'($signed(in_sample)));
        if (frame.size() == NV) begin
          sum = 0;
          foreach (frame[k]) sum += frame[k];
          ld   = scale(sum, int'(gain_shift));
          load = 1;
          collecting = 1'b0;
        end
      end else begin
        seq_set    = 1;
        collecting = 1'b0;
      end
    end
    if (load) begin
      if (m_valid && !out_ready) ovr_set = 1;
      m_valid  = 1'b1;
      m_sample = ld;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (seq_set) m_seq = 1'b1; else if (clear_flags) m_seq = 1'b0;
    if (ovr_set) m_ovr = 1'b1; else if (clear_flags) m_ovr = 1'b0;
  endtask

  // Drive one cycle of inputs, advance model and DUT, then compare #1 after the edge.
  task automatic step(input string tag, input logic v, input int voice, input int s,
                      input int g, input logic rdy, input logic clr);
    in_valid    = v;
    in_voice    = 8'(voice);
    in_sample   = 16'(s);
    gain_shift  = 4'(g);
    out_ready   = rdy;
    clear_flags = clr;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic rdy);
    step(tag, 1'b0, 0, 0, 0, rdy, 1'b0);
  endtask

  task automatic frame4(input string tag, input int a, input int b, input int c,
                        input int d, input int g, input logic rdy);
    step(tag, 1'b1, 0, a, g, rdy, 1'b0);
    step(tag, 1'b1, 1, b, g, rdy, 1'b0);
    step(tag, 1'b1, 2, c, g, rdy, 1'b0);
    step(tag, 1'b1, 3, d, g, rdy, 1'b0);
  endtask

  initial begin
    int next_voice;
    int pick;
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_voice    = 8'd0;
    in_sample   = 16'd0;
    gain_shift  = 4'd0;
    clear_flags = 1'b0;
    out_ready   = 1'b0;
    model_reset();

    // Reset state.
    @(posedge clk); #1;
    check_all("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    idle("post_reset", 1'b1);

    // Basic sum: 1000 + 2000 - 500 + 4.
    frame4("sum", 1000, 2000, -500, 4, 0, 1'b1);
    check("sum.const", {16'd0, out_sample}, 32'd2504);
    idle("sum.pulse", 1'b1);
    check("sum.pulse_low", {31'd0, out_valid}, 32'd0);

    // Clamp / wrap of 64000, then the same with a shift of 2.
    frame4("clamp", 16000, 16000, 16000, 16000, 0, 1'b1);
`ifdef VOICE_MIXER_SATURATE_EN
    check("clamp.const", {16'd0, out_sample}, 32'd32767);
`else
    check("clamp.const", {16'd0, out_sample}, {16'd0, 16'hfa00});
`endif
    frame4("clamp_g2", 16000, 16000, 16000, 16000, 2, 1'b1);
    check("clamp_g2.const", {16'd0, out_sample}, 32'd16000);

    // Negative total: -64000.
    frame4("neg", -16000, -16000, -16000, -16000, 0, 1'b1);
    idle("neg.drain", 1'b1);

    // Sequence fault then a clean frame, then clear the flag.
    step("seq", 1'b1, 0, 7, 0, 1'b1, 1'b0);
    step("seq", 1'b1, 1, 7, 0, 1'b1, 1'b0);
    step("seq", 1'b1, 3, 7, 0, 1'b1, 1'b0);
    step("seq", 1'b1, 2, 7, 0, 1'b1, 1'b0);
    check("seq.flag", {31'd0, seq_err}, 32'd1);
    frame4("seq.clean", 100, 100, 100, 100, 0, 1'b1);
    check("seq.clean_const", {16'd0, out_sample}, 32'd400);
    step("seq.clear", 1'b0, 0, 0, 0, 1'b1, 1'b1);
    check("seq.cleared", {31'd0, seq_err}, 32'd0);

    // Ignored out-of-range voice in the middle of a frame.
    step("range", 1'b1, 0, 3, 1, 1'b1, 1'b0);
    step("range", 1'b1, 9, 999, 1, 1'b1, 1'b0);
    step("range", 1'b1, 1, 3, 1, 1'b1, 1'b0);
    step("range", 1'b1, 2, 3, 1, 1'b1, 1'b0);
    step("range", 1'b1, 3, 3, 1, 1'b1, 1'b0);
    idle("range.drain", 1'b1);

    // Back-pressure: two frames without a handshake.
    frame4("bp1", 1, 2, 3, 4, 0, 1'b0);
    frame4("bp2", 5, 5, 5, 5, 0, 1'b0);
    check("bp.const", {16'd0, out_sample}, 32'd20);
    check("bp.overrun", {31'd0, overrun}, 32'd1);
    idle("bp.handshake", 1'b1);
    check("bp.drained", {31'd0, out_valid}, 32'd0);
    step("bp.clear", 1'b0, 0, 0, 0, 1'b1, 1'b1);

    // Asynchronous reset mid-frame.
    step("rst", 1'b1, 0, 5, 0, 1'b1, 1'b0);
    step("rst", 1'b1, 1, 5, 0, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("rst.async");
    @(posedge clk); #1;
    check_all("rst.held");
    reset = 1'b1;
    step("rst.orphan", 1'b1, 2, 5, 0, 1'b1, 1'b0);
    step("rst.orphan", 1'b1, 3, 5, 0, 1'b1, 1'b0);
    check("rst.no_out", {31'd0, out_valid}, 32'd0);
    frame4("rst.frame", 5, 5, 5, 5, 0, 1'b1);
    check("rst.const", {16'd0, out_sample}, 32'd20);

    // Randomized traffic: mostly in-order slots with occasional faults.
    next_voice = 0;
    for (int i = 0; i < 400; i++) begin
      pick = int'($urandom_range(0, 9));
      if (pick < 7) begin
        step("rand", 1'b1, next_voice, int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 15) == 0));
        next_voice = (next_voice + 1) % NV;
      end else if (pick < 9) begin
        step("rand", 1'b1, int'($urandom_range(0, 5)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0));
      end else begin
        step("rand", 1'b0, 0, 0, 0, 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
